// File: rtl/proc_defs_pkg.sv
// Shared core definitions: opcode constants and PC sequencer state encoding.
package proc_defs_pkg;

  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1001;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } seq_state_e;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/pc_seq_ctrl_if.sv
// Sequencer-to-core bundle: decode/EX/memory inputs in, PC and stall controls out.
interface pc_seq_ctrl_if #(parameter int PC_W = 16);

  logic [3:0]      opcode;
  logic [PC_W-1:0] alt_pc;
  logic            alt_pc_ctrl;
  logic            dst_we_req;
  logic            mem_rdy;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_inc;
  logic            stall;
  logic            mem_req;
  logic            rf_we;
  logic            halted;
  logic            mem_err;

  modport master (
    output opcode, alt_pc, alt_pc_ctrl, dst_we_req, mem_rdy,
    input  pc, pc_inc, stall, mem_req, rf_we, halted, mem_err
  );

  modport slave (
    input  opcode, alt_pc, alt_pc_ctrl, dst_we_req, mem_rdy,
    output pc, pc_inc, stall, mem_req, rf_we, halted, mem_err
  );

endinterface

// File: rtl/pc_seq_ctrl.sv
// PC sequencer / stall controller: non-memory ops retire in 1 cycle, LW/SW in 1+N.
// Stalls while mem_rdy is low; halts on HLT or after MEM_TIMEOUT wait cycles.
module pc_seq_ctrl
  import proc_defs_pkg::*;
#(
  parameter int              PC_W        = 16,
  parameter logic [PC_W-1:0] RST_PC      = '0,
  parameter int              MEM_TIMEOUT = 15
) (
  input logic          clk,
  input logic          rst,
  pc_seq_ctrl_if.slave bus
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  seq_state_e      state;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_inc;
  logic [7:0]      wait_cnt;
  logic            halted_q;
  logic            mem_err_q;
  logic            stall;
  logic            mem_req;
  logic            rf_we;
  logic            mem_op;
  logic            hlt_op;

  assign pc_inc = pc_q + PC_W'(1);
  assign mem_op = is_mem_op(bus.opcode);
  assign hlt_op = (bus.opcode == OP_HLT);

  // Reset masks the decode so an in-flight memory request drops immediately.
  always_comb begin
    stall   = 1'b0;
    mem_req = 1'b0;
    rf_we   = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          if (mem_op) begin
            mem_req = 1'b1;
            if (bus.mem_rdy) rf_we = bus.dst_we_req;
            else             stall = 1'b1;
          end else if (hlt_op) begin
            stall = 1'b1;
          end else begin
            rf_we = bus.dst_we_req;
          end
        end
        MEM_WAIT: begin
          mem_req = 1'b1;
          if (bus.mem_rdy) rf_we = bus.dst_we_req;
          else             stall = 1'b1;
        end
        default: stall = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      pc_q      <= RST_PC;
      wait_cnt  <= 8'd0;
      halted_q  <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_op) begin
            if (bus.mem_rdy) begin
              pc_q <= pc_inc;
            end else begin
              wait_cnt <= 8'd1;
              state    <= MEM_WAIT;
            end
          end else if (hlt_op) begin
            state    <= HALT;
            halted_q <= 1'b1;
          end else begin
            pc_q <= bus.alt_pc_ctrl ? bus.alt_pc : pc_inc;
          end
        end
        MEM_WAIT: begin
          if (bus.mem_rdy) begin
            pc_q     <= pc_inc;
            wait_cnt <= 8'd0;
            state    <= RUN;
          end else if (wait_cnt == TIMEOUT_CNT) begin
            state     <= HALT;
            halted_q  <= 1'b1;
            mem_err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        HALT: ;
        default: state <= RUN;
      endcase
    end
  end

  assign bus.pc      = pc_q;
  assign bus.pc_inc  = pc_inc;
  assign bus.stall   = stall;
  assign bus.mem_req = mem_req;
  assign bus.rf_we   = rf_we;
  assign bus.halted  = halted_q;
  assign bus.mem_err = mem_err_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl: directed scenarios then random opcode/handshake traffic vs a cycle model.
module tb_pc_seq_ctrl;
  import proc_defs_pkg::OP_LW;
  import proc_defs_pkg::OP_SW;
  import proc_defs_pkg::OP_HLT;

  localparam int TMO    = 15;
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_BR  = 4'hC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_seq_ctrl_if #(.PC_W(16)) bus ();

  pc_seq_ctrl #(.PC_W(16), .RST_PC(16'h0000), .MEM_TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference: PC as an integer modulo 2^16, cycles spent waiting on the current memory op,
  // and sticky halted / error flags.
  int m_pc     = 0;
  int m_wait   = 0;
  bit m_halted = 1'b0;
  bit m_err    = 1'b0;
  logic [3:0] last_op = OP_ADD;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst         = 1'b1;
      bus.mem_rdy = 1'b0;
      #1;
      chk("rst_stall", 32'(bus.stall), 32'd0);
      chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
      chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
      @(posedge clk);
      #1;
      m_pc = 0; m_wait = 0; m_halted = 1'b0; m_err = 1'b0;
      chk("rst_pc", 32'(bus.pc), 32'd0);
      chk("rst_halted", 32'(bus.halted), 32'd0);
      chk("rst_mem_err", 32'(bus.mem_err), 32'd0);
    end
  endtask

  task automatic step(input logic [3:0] op, input logic [15:0] apc, input logic actl,
                      input logic we, input logic rdy);
    int e_stall, e_req, e_we, n_pc, n_wait;
    bit n_halt, n_err;
    @(negedge clk);
    rst             = 1'b0;
    bus.opcode      = op;
    bus.alt_pc      = apc;
    bus.alt_pc_ctrl = actl;
    bus.dst_we_req  = we;
    bus.mem_rdy     = rdy;
    last_op         = op;
    e_stall = 0; e_req = 0; e_we = 0;
    n_pc = m_pc; n_wait = m_wait; n_halt = 1'b0; n_err = 1'b0;
    if (m_halted) begin
      e_stall = 1;
    end else if (m_wait > 0 || op == OP_LW || op == OP_SW) begin
      e_req = 1;
      if (rdy) begin
        e_we = int'(we); n_pc = (m_pc + 1) % 65536; n_wait = 0;
      end else if (m_wait == TMO) begin
        e_stall = 1; n_halt = 1'b1; n_err = 1'b1;
      end else begin
        e_stall = 1; n_wait = m_wait + 1;
      end
    end else if (op == OP_HLT) begin
      e_stall = 1; n_halt = 1'b1;
    end else begin
      e_we = int'(we);
      n_pc = actl ? int'(apc) : (m_pc + 1) % 65536;
    end
    #1;
    chk("stall", 32'(bus.stall), 32'(e_stall));
    chk("mem_req", 32'(bus.mem_req), 32'(e_req));
    chk("rf_we", 32'(bus.rf_we), 32'(e_we));
    chk("pc_inc", 32'(bus.pc_inc), 32'((m_pc + 1) % 65536));
    @(posedge clk);
    #1;
    m_pc = n_pc; m_wait = n_wait;
    m_halted = m_halted | n_halt;
    m_err    = m_err | n_err;
    chk("pc", 32'(bus.pc), 32'(m_pc));
    chk("halted", 32'(bus.halted), 32'(m_halted));
    chk("mem_err", 32'(bus.mem_err), 32'(m_err));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    bit stubborn;
    logic [3:0] op;
    bus.opcode = OP_ADD; bus.alt_pc = '0; bus.alt_pc_ctrl = 1'b0;
    bus.dst_we_req = 1'b0; bus.mem_rdy = 1'b0;

    // Straight-line ADDs from reset, then a taken branch at pc=5.
    do_reset(2);
    for (int i = 0; i < 5; i++) step(OP_ADD, 16'h1234, 1'b0, 1'(i % 2), 1'b0);
    step(OP_BR, 16'h0040, 1'b1, 1'b0, 1'b0);
    chk("branch_target", 32'(bus.pc), 32'h0040);

    // LW at pc=7 acked on the fourth cycle.
    step(OP_BR, 16'h0007, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(OP_LW, 16'h0100, 1'b1, 1'b1, 1'(i == 3));
    chk("lw_done_pc", 32'(bus.pc), 32'h0008);

    // SW that never acks: timeout halt, then everything ignored.
    for (int i = 0; i < 16; i++) step(OP_SW, 16'h0000, 1'b0, 1'b1, 1'b0);
    chk("timeout_err", 32'(bus.mem_err), 32'd1);
    for (int i = 0; i < 3; i++) step(OP_ADD, 16'h0055, 1'b1, 1'b1, 1'b1);

    // HLT at the top of the address space, then wrap of an ADD there.
    do_reset(1);
    step(OP_BR, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    step(OP_HLT, 16'h0000, 1'b0, 1'b1, 1'b0);
    step(OP_LW, 16'h0022, 1'b1, 1'b1, 1'b1);
    chk("hlt_pc_frozen", 32'(bus.pc), 32'hFFFF);
    do_reset(1);
    step(OP_BR, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    step(OP_ADD, 16'h0000, 1'b0, 1'b1, 1'b0);
    chk("wrap_pc", 32'(bus.pc), 32'h0000);

    // Reset while waiting on memory.
    step(OP_LW, 16'h0000, 1'b0, 1'b1, 1'b0);
    step(OP_LW, 16'h0000, 1'b0, 1'b1, 1'b0);
    do_reset(1);
    step(OP_ADD, 16'h0000, 1'b0, 1'b1, 1'b0);

    stubborn = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (m_halted && $urandom_range(0, 3) == 0) begin
        do_reset(1);
        continue;
      end
      if (m_wait > 0) begin
        op = last_op;
      end else begin
        case ($urandom_range(0, 99)) inside
          [0:59]:  op = 4'($urandom_range(0, 7));
          [60:69]: op = 4'($urandom_range(10, 14));
          [70:83]: op = OP_LW;
          [84:96]: op = OP_SW;
          default: op = OP_HLT;
        endcase
        stubborn = ($urandom_range(0, 19) == 0);
      end
      step(op, 16'($urandom), 1'($urandom), 1'($urandom),
           stubborn ? 1'b0 : 1'($urandom_range(0, 2) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
